// File: rtl/nested_struct_queue.sv
// nested_struct_queue: FWFT queue of nested structs with drop counting and flush
// Ports: clk/rst_n (async active-low) clock and reset; in_data struct input, qualified
// by base.valid; flush clears contents and drop count; out_data/out_valid/out_ready
// head entry handshake; count stored entries; full count==DEPTH; drop_cnt saturating
// count of qualified structs lost to a full queue.
package main_pkg;
  typedef struct packed {
    logic        valid;
    logic [4:0]  kind;
    logic [15:0] id;
  } base_t;
  typedef struct packed {
    base_t       base;
    logic [7:0]  addr;
    logic [31:0] data;
  } nested_struct_t;
endpackage

module nested_struct_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  main_pkg::nested_struct_t     in_data,
  input  logic                         flush,
  output main_pkg::nested_struct_t     out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic [7:0]                   drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  main_pkg::nested_struct_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_req, pop, accept;
  assign push_req  = in_data.base.valid;
  assign out_valid = count != '0;
  assign full      = count == CW'(DEPTH);
  assign pop       = out_valid & out_ready;
  // a full queue still takes a push when the head leaves in the same cycle
  assign accept    = push_req & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (accept && !flush) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= accept ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count    <= count + CW'(accept) - CW'(pop);
      drop_cnt <= (push_req && !accept && drop_cnt != 8'hff) ? drop_cnt + 8'd1 : drop_cnt;
    end
endmodule

// File: tb/tb_nested_struct_queue.sv
// tb_nested_struct_queue: table-driven and directed checks of nested_struct_queue
module tb_nested_struct_queue;
  import main_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, out_ready = 0;
  nested_struct_t in_data = '0, out_data;
  logic out_valid, full;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  int total = 0, bad = 0;

  nested_struct_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic nested_struct_t mk(input logic [15:0] id);
    nested_struct_t s;
    s.base.valid = 1'b1;
    s.base.kind  = id[4:0] ^ 5'h15;
    s.base.id    = id;
    s.addr       = id[7:0] ^ 8'h5a;
    s.data       = {~id, id};
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] id;
    logic        fl;
    logic        rdy;
    logic [2:0]  c;
    logic        ov;
    logic [15:0] hid;
    logic [7:0]  dc;
    logic        fu;
  } vec_t;

  vec_t vt [19];

  initial begin
    vt[0]  = '{1, 16'h0001, 0, 0, 3'd1, 1, 16'h0001, 8'd0, 0};
    vt[1]  = '{1, 16'h0002, 0, 0, 3'd2, 1, 16'h0001, 8'd0, 0};
    vt[2]  = '{1, 16'h0003, 0, 0, 3'd3, 1, 16'h0001, 8'd0, 0};
    vt[3]  = '{0, 16'h0000, 0, 1, 3'd2, 1, 16'h0002, 8'd0, 0};
    vt[4]  = '{0, 16'h0000, 0, 1, 3'd1, 1, 16'h0003, 8'd0, 0};
    vt[5]  = '{0, 16'h0000, 0, 1, 3'd0, 0, 16'h0000, 8'd0, 0};
    vt[6]  = '{0, 16'h0000, 0, 1, 3'd0, 0, 16'h0000, 8'd0, 0};
    vt[7]  = '{1, 16'h0011, 0, 0, 3'd1, 1, 16'h0011, 8'd0, 0};
    vt[8]  = '{1, 16'h0012, 0, 0, 3'd2, 1, 16'h0011, 8'd0, 0};
    vt[9]  = '{1, 16'h0013, 0, 0, 3'd3, 1, 16'h0011, 8'd0, 0};
    vt[10] = '{1, 16'h0014, 0, 0, 3'd4, 1, 16'h0011, 8'd0, 1};
    vt[11] = '{1, 16'h0015, 0, 0, 3'd4, 1, 16'h0011, 8'd1, 1};
    vt[12] = '{1, 16'h0016, 0, 0, 3'd4, 1, 16'h0011, 8'd2, 1};
    vt[13] = '{1, 16'h0017, 0, 1, 3'd4, 1, 16'h0012, 8'd2, 1};
    vt[14] = '{0, 16'h0000, 0, 1, 3'd3, 1, 16'h0013, 8'd2, 0};
    vt[15] = '{0, 16'h0000, 0, 1, 3'd2, 1, 16'h0014, 8'd2, 0};
    vt[16] = '{0, 16'h0000, 0, 1, 3'd1, 1, 16'h0017, 8'd2, 0};
    vt[17] = '{1, 16'h0099, 1, 1, 3'd0, 0, 16'h0000, 8'd0, 0};
    vt[18] = '{0, 16'h0000, 0, 1, 3'd0, 0, 16'h0000, 8'd0, 0};

    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    step();
    rst_n = 1;

    for (int i = 0; i < 19; i++) begin
      in_data   = vt[i].v ? mk(vt[i].id) : '0;
      flush     = vt[i].fl;
      out_ready = vt[i].rdy;
      step();
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].c));
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].ov));
      chk($sformatf("v%0d_full", i), 64'(full), 64'(vt[i].fu));
      chk($sformatf("v%0d_drop", i), 64'(drop_cnt), 64'(vt[i].dc));
      chk($sformatf("v%0d_data", i), 64'(out_data), vt[i].ov ? 64'(mk(vt[i].hid)) : 64'd0);
    end
    flush = 0;

    in_data = mk(16'h7777);
    in_data.base.valid = 1'b0;
    out_ready = 0;
    for (int i = 0; i < 10; i++) step();
    chk("unq_count", 64'(count), 64'd0);
    chk("unq_drop", 64'(drop_cnt), 64'd0);
    chk("unq_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 300; i++) begin
      in_data = mk(16'(16'h0100 + i));
      step();
    end
    chk("sat_drop", 64'(drop_cnt), 64'd255);
    chk("sat_full", 64'(full), 64'd1);
    chk("sat_head", 64'(out_data), 64'(mk(16'h0100)));
    flush = 1;
    step();
    flush = 0;
    in_data = '0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd0);
    chk("flush_data", 64'(out_data), 64'd0);

    in_data = mk(16'h0201);
    step();
    in_data = mk(16'h0202);
    step();
    in_data = '0;
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    rst_n = 0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    #3;
    rst_n = 1;
    in_data = mk(16'h0303);
    in_data.addr = 8'h10;
    in_data.data = 32'hDEADBEEF;
    step();
    in_data = '0;
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_addr", 64'(out_data.addr), 64'h10);
    chk("post_rst_data", 64'(out_data.data), 64'hDEADBEEF);
    chk("post_rst_id", 64'(out_data.base.id), 64'h0303);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nested_struct_queue.md
NESTED_STRUCT_QUEUE -- requirements
Module: nested_struct_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of 2, >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_data  input  main_pkg::nested_struct_t (62)  struct from the upstream nested_struct stage, sampled every cycle.
REQ-005 SHALL have port flush  input  1  synchronous clear of queue contents and drop count.
REQ-006 SHALL have port out_data  output  main_pkg::nested_struct_t (62)  head-of-queue entry.
REQ-007 SHALL have port out_valid  output  1  queue holds at least one entry.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-010 SHALL have port full  output  1  count == DEPTH.
REQ-011 SHALL have port drop_cnt  output  8  saturating count of qualified structs lost to a full queue.

Function
REQ-012 SHALL treat in_data as qualified (push request) when in_data.base.valid == 1; unqualified cycles are ignored and not counted.
REQ-013 SHALL define pop = out_valid & out_ready; out_ready while out_valid == 0 has no effect.
REQ-014 SHALL accept a push when count < DEPTH, or when count == DEPTH and pop is asserted the same cycle.
REQ-015 SHALL, on a qualified struct that is not accepted, increment drop_cnt by 1, saturating at 255, with no change to queue contents.
REQ-016 SHALL store the full 62-bit struct unmodified, all nested base fields included.
REQ-017 SHALL present the oldest entry on out_data combinationally from storage (first-word-fall-through), with out_valid = (count != 0).
REQ-018 SHALL have one-cycle latency: a struct pushed into an empty queue on edge N appears on out_data, with out_valid = 1, after edge N; there is no same-cycle bypass.
REQ-019 SHALL, on simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL drive out_data to all zeros whenever out_valid == 0.
REQ-022 SHALL, when flush == 1, take priority over push and pop that cycle: count and pointers go to 0, drop_cnt goes to 0, and the incoming struct is discarded and not counted.
REQ-023 SHALL drive full = (count == DEPTH).

Reset
REQ-024 SHALL, while rst_n == 0, immediately force count = 0, pointers = 0, drop_cnt = 0, out_valid = 0, full = 0 and out_data = '0, independent of clk.
REQ-025 SHALL, on reset asserted mid-operation, discard all stored entries; the first qualified struct after rst_n deassertion is accepted as a push into an empty queue.
REQ-026 SHALL leave storage contents unreset (don't-care), since out_data is masked by REQ-021.

Verification
REQ-027 SHALL cover this scenario: push base.valid=1 with id=0x0001, 0x0002, 0x0003 and out_ready=0 -> count=3; then out_ready=1 -> out_data.id reads 0x0001, 0x0002, 0x0003 on consecutive cycles, then out_valid=0.
REQ-028 SHALL cover this scenario: DEPTH=4 with 6 qualified pushes and out_ready=0 -> full=1, count=4, drop_cnt=2, head id is the first pushed.
REQ-029 SHALL cover this scenario: full queue with qualified push and out_ready=1 in the same cycle -> push accepted, count stays 4, drop_cnt unchanged, tail holds the new struct.
REQ-030 SHALL cover this scenario: in_data.base.valid=0 held with other fields non-zero for 10 cycles -> count=0, drop_cnt=0, out_valid=0.
REQ-031 SHALL cover this scenario: 300 qualified pushes into a full queue with out_ready=0 -> drop_cnt=255 (saturated); then flush=1 for one cycle -> count=0, drop_cnt=0, out_data=0.
REQ-032 SHALL cover this scenario: rst_n pulled low between clock edges with count=2 -> out_valid=0 and count=0 immediately; after release, a push of addr=0x10, data=0xDEADBEEF returns those exact field values on out_data.
